// File: rtl/step3_action_select.sv
// PBVI backup step 3: per-belief dot product against each action's candidate
// vector, argmax over actions, one belief point per cycle through a two-stage pipe.
module step3_action_select #(
    parameter int N_BELIEF = 16,
    parameter int N_ACTION = 3,
    parameter int N_STATE  = 2,
    parameter int W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [W-1:0]      gamma_action_belief [0:N_ACTION-1][0:N_BELIEF-1][0:N_STATE-1],
    input  logic [W-1:0]      point_belief        [0:N_BELIEF-1][0:N_STATE-1],
    output logic              busy,
    output logic              done,
    output logic [W-1:0]      alpha_next          [0:N_BELIEF-1][0:N_STATE-1],
    output logic [1:0]        best_action         [0:N_BELIEF-1],
    output logic [2*W:0]      best_value          [0:N_BELIEF-1]
);

    localparam int IW = $clog2(N_BELIEF);
    localparam int DW = 2 * W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            va_q, va_d;
    logic [IW-1:0]   ia_q, ia_d;
    logic [DW-1:0]   dot_q [0:N_ACTION-1];
    logic [DW-1:0]   dot_d [0:N_ACTION-1];
    logic [W-1:0]    alpha_q [0:N_BELIEF-1][0:N_STATE-1];
    logic [W-1:0]    alpha_d [0:N_BELIEF-1][0:N_STATE-1];
    logic [1:0]      act_q [0:N_BELIEF-1];
    logic [1:0]      act_d [0:N_BELIEF-1];
    logic [DW-1:0]   val_q [0:N_BELIEF-1];
    logic [DW-1:0]   val_d [0:N_BELIEF-1];
    logic [1:0]      best;
    logic [DW-1:0]   best_dot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            va_q    <= 1'b0;
            ia_q    <= '0;
            dot_q   <= '{default: '0};
            alpha_q <= '{default: '{default: '0}};
            act_q   <= '{default: '0};
            val_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            va_q    <= va_d;
            ia_q    <= ia_d;
            dot_q   <= dot_d;
            alpha_q <= alpha_d;
            act_q   <= act_d;
            val_q   <= val_d;
        end
    end

    // en in any state (re)starts a run at index 0; an aborted run never reaches DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: if (en) begin
                state_d = S_RUN;
                idx_d   = '0;
            end
            S_RUN: begin
                if (en) begin
                    idx_d = '0;
                end else if (idx_q == IW'(N_BELIEF - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = en ? S_RUN : S_DONE;
                idx_d   = '0;
            end
            S_DONE: begin
                state_d = en ? S_RUN : S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // Stage A: full-width dot products, never truncated
    always_comb begin
        va_d = (state_q == S_RUN);
        ia_d = idx_q;
        for (int a = 0; a < N_ACTION; a++) begin
            dot_d[a] = DW'(32'(gamma_action_belief[a][idx_q][0]) * 32'(point_belief[idx_q][0]))
                     + DW'(32'(gamma_action_belief[a][idx_q][1]) * 32'(point_belief[idx_q][1]));
        end
    end

    // Stage B: strict compare keeps the lowest action index on ties
    always_comb begin
        best     = 2'd0;
        best_dot = dot_q[0];
        for (int a = 1; a < N_ACTION; a++) begin
            if (dot_q[a] > best_dot) begin
                best_dot = dot_q[a];
                best     = 2'(a);
            end
        end
        alpha_d = alpha_q;
        act_d   = act_q;
        val_d   = val_q;
        if (va_q) begin
            for (int s = 0; s < N_STATE; s++) begin
                alpha_d[ia_q][s] = gamma_action_belief[best][ia_q][s];
            end
            act_d[ia_q] = best;
            val_d[ia_q] = best_dot;
        end
    end

    assign alpha_next  = alpha_q;
    assign best_action = act_q;
    assign best_value  = val_q;

endmodule

// File: tb/tb_step3_action_select.sv
// Scoreboard bench for step3_action_select: stimulus pushes the expected run
// result, a negedge monitor pops and checks it whenever done pulses.
module tb_step3_action_select;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] g [0:2][0:15][0:1];
    logic [15:0] b [0:15][0:1];
    logic        busy, done;
    logic [15:0] alpha_next [0:15][0:1];
    logic [1:0]  best_action [0:15];
    logic [32:0] best_value [0:15];

    int n_cmp = 0;
    int n_bad = 0;
    int e = 0;

    typedef struct {
        int                done_at;
        logic [15:0][15:0] al0;
        logic [15:0][15:0] al1;
        logic [15:0][1:0]  act;
        logic [15:0][32:0] val;
    } exp_t;

    exp_t sb[$];

    step3_action_select dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .gamma_action_belief (g),
        .point_belief        (b),
        .busy                (busy),
        .done                (done),
        .alpha_next          (alpha_next),
        .best_action         (best_action),
        .best_value          (best_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) e <= e + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic set_pattern(input int p);
        for (int i = 0; i < 16; i++) begin
            for (int a = 0; a < 3; a++) begin
                case (p)
                    1: begin g[a][i][0] = 16'(10 * (a + 1)); g[a][i][1] = 16'd7; end
                    2: begin
                        g[a][i][0] = (a == 0) ? 16'd3 : (a == 1) ? 16'd0 : 16'd6;
                        g[a][i][1] = (a == 0) ? 16'd2 : (a == 1) ? 16'd4 : 16'd0;
                    end
                    3: begin g[a][i][0] = 16'hFFFF; g[a][i][1] = 16'hFFFF; end
                    4: begin g[a][i][0] = (a == 1) ? 16'd1 : 16'd0; g[a][i][1] = 16'd0; end
                    default: begin g[a][i][0] = 16'd9; g[a][i][1] = (a == 1) ? 16'd100 : 16'd50; end
                endcase
            end
            case (p)
                1: begin b[i][0] = 16'd1; b[i][1] = 16'd0; end
                2: begin b[i][0] = 16'd2; b[i][1] = 16'd3; end
                3: begin b[i][0] = 16'hFFFF; b[i][1] = 16'hFFFF; end
                4: begin b[i][0] = 16'(i); b[i][1] = 16'd1; end
                default: begin b[i][0] = 16'd0; b[i][1] = 16'd1; end
            endcase
        end
    endtask

    // Hand-derived results per pattern
    function automatic exp_t make_exp(input int p, input int done_at);
        exp_t x;
        x.done_at = done_at;
        for (int i = 0; i < 16; i++) begin
            case (p)
                1: begin x.al0[i] = 16'd30; x.al1[i] = 16'd7; x.act[i] = 2'd2; x.val[i] = 33'd30; end
                2: begin x.al0[i] = 16'd3; x.al1[i] = 16'd2; x.act[i] = 2'd0; x.val[i] = 33'd12; end
                3: begin x.al0[i] = 16'hFFFF; x.al1[i] = 16'hFFFF; x.act[i] = 2'd0; x.val[i] = 33'h1_FFFC_0002; end
                4: begin
                    x.al0[i] = (i == 0) ? 16'd0 : 16'd1;
                    x.al1[i] = 16'd0;
                    x.act[i] = (i == 0) ? 2'd0 : 2'd1;
                    x.val[i] = 33'(i);
                end
                default: begin x.al0[i] = 16'd9; x.al1[i] = 16'd100; x.act[i] = 2'd1; x.val[i] = 33'd100; end
            endcase
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (edge %0d)", e);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("done_time", 64'(e), 64'(x.done_at));
                for (int i = 0; i < 16; i++) begin
                    chk($sformatf("point%0d", i),
                        {alpha_next[i][0], alpha_next[i][1], best_action[i], best_value[i]},
                        {x.al0[i], x.al1[i], x.act[i], x.val[i]});
                end
            end
        end
    end

    task automatic pulse_en(output int t_en);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        t_en = e;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0, t1;
        set_pattern(1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle without en: nothing moves, outputs stay zero
        repeat (10) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_val0", 64'(best_value[0]), 64'd0);
        chk("idle_alpha15", 64'({alpha_next[15][0], alpha_next[15][1]}), 64'd0);

        // Basic argmax, plus busy window
        pulse_en(t0);
        sb.push_back(make_exp(1, t0 + 17));
        chk("busy_first", 64'(busy), 64'd1);
        repeat (16) @(negedge clk);
        chk("busy_last", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_done_cycle", 64'(busy), 64'd0);
        wait_drain();

        // Tie-break to lowest action
        set_pattern(2);
        pulse_en(t0);
        sb.push_back(make_exp(2, t0 + 17));
        wait_drain();

        // Full 33-bit sum
        set_pattern(3);
        pulse_en(t0);
        sb.push_back(make_exp(3, t0 + 17));
        wait_drain();

        // Per-index write timing: entry i changes exactly at edge t0+2+i
        set_pattern(4);
        pulse_en(t0);
        sb.push_back(make_exp(4, t0 + 17));
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("busy_k%0d", k), 64'(busy), (k <= 16) ? 64'd1 : 64'd0);
            if (k >= 2) chk($sformatf("new_val%0d", k - 2), 64'(best_value[k - 2]), 64'(k - 2));
            if (k >= 1 && k <= 16)
                chk($sformatf("old_val%0d", k - 1), 64'(best_value[k - 1]), 64'h1_FFFC_0002);
        end
        wait_drain();

        // Restart five cycles in: only the second run completes
        set_pattern(5);
        pulse_en(t0);
        repeat (3) @(negedge clk);
        pulse_en(t1);
        chk("restart_offset", 64'(t1 - t0), 64'd5);
        sb.push_back(make_exp(5, t1 + 17));
        wait_drain();

        // Async reset mid-run: outputs cleared, no done afterwards
        set_pattern(1);
        pulse_en(t0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rst_point%0d", i),
                {alpha_next[i][0], alpha_next[i][1], best_action[i], best_value[i]}, 64'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_val7", 64'(best_value[7]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/step3_action_select.md
Name: step3_action_select

Overview:
- Per-belief action maximisation stage of the PBVI backup. It sits directly downstream of the step2 per-action back-projection stage.
- For each of the 16 belief points it computes the dot product of the belief with each of the 3 candidate action vectors gamma_action_belief[a][i].
- It selects the maximising action and registers that action's 2-state vector as the new alpha vector for the point, together with the action index and value.
- It is a sequential, two-stage pipeline that processes one belief point per cycle and signals completion with a done pulse.

Parameters:
- N_BELIEF, 16, number of belief points and output alpha vectors
- N_ACTION, 3, number of candidate actions
- N_STATE, 2, vector length (states)
- W, 16, element width of belief and gamma values (unsigned)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  start pulse; same signal as step2's en_step3
- gamma_action_belief  in  16 [0:2][0:15][0:1]  per-action, per-belief candidate vectors; unsigned
- point_belief  in  16 [0:15][0:1]  belief points; unsigned
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when all 16 results are valid
- alpha_next  out  16 [0:15][0:1]  selected vector per belief point
- best_action  out  2 [0:15]  selected action index per belief point (0..2)
- best_value  out  33 [0:15]  maximised dot product per belief point

Behaviour:
- Reset: all outputs 0; FSM in IDLE; belief counter 0; pipeline valid bit 0.
- Input stability: gamma_action_belief and point_belief must be held stable from the en cycle until done. The block does not latch them.
- FSM states and transitions:
  - IDLE: en=1 moves to RUN; belief counter cleared.
  - RUN: one belief index issued per cycle, idx 0..15. After issuing idx 15, move to DRAIN.
  - DRAIN: one cycle, so the last result is written. Then move to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in RUN and DRAIN; busy=0 in IDLE and DONE.
- Stage A (issue cycle of idx i):
  - For a in 0..2: dot[a] = g[a][i][0]*b[i][0] + g[a][i][1]*b[i][1].
  - Each product is 32 bits; the sum is 33 bits and is never truncated.
  - dot[0..2], idx and valid are registered.
- Stage B (next cycle), argmax:
  - Start from action 0; replace the current best only if dot[a] > current best (strict).
  - Ties therefore resolve to the lowest action index.
  - Register alpha_next[idx] = g[best][idx][*], best_action[idx] = best, best_value[idx] = max.
- Latency: if en is sampled at edge T, belief i is issued in cycle T+1+i and its outputs are visible from cycle T+3+i.
  - Belief 15 is visible from T+18.
  - done is high in cycle T+18.
  - Total run length is 18 cycles.
- Entries not yet written in the current run keep their previous-run values. Outputs are not cleared at start.
- en while busy (RUN/DRAIN): restart from idx 0.
  - The in-flight stage-B write still completes.
  - No done pulse is produced for the aborted run.
- en in DONE cycle: done still pulses; the FSM goes to RUN (new run).
- Async reset mid-run: immediate return to IDLE with all outputs 0; no done.
- Arithmetic is unsigned throughout; no overflow is possible (max 2*(2^16-1)^2 < 2^33).

Test Plan:
- Reset/idle: assert rst_n=0 mid-simulation -> all alpha_next/best_action/best_value 0, busy=0, done=0; no activity without en.
- Basic argmax:
  - Stimulus: b[i]=(1,0) for all i; g[a][i]=(10*(a+1),7); pulse en at edge T.
  - Expected: done at T+18, busy high T+1..T+17.
  - Per point: best_action=2, alpha_next=(30,7), best_value=30.
- Tie-break: b[i]=(2,3); g[0][i]=(3,2), g[1][i]=(0,4), g[2][i]=(6,0) (all dot=12) -> best_action=0, alpha_next=(3,2), best_value=12.
- Width/overflow: all b and g = 0xFFFF -> best_value = 0x1_FFFC_0002 (33-bit) for every point, best_action=0.
- Per-index pipeline timing:
  - Stimulus: b[i]=(i,1); g[1][i]=(1,0), others 0.
  - Expected: best_action[0]=0 (all zero, tie), best_action[i]=1 for i>=1, best_value[i]=i.
  - Entry i updates exactly at cycle T+3+i.
- Restart/abort: pulse en at T, again at T+5 -> single done at T+23, no done at T+18; results correct for final inputs. Separately, drop rst_n at T+8 -> outputs 0, no done.
